// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch front end.
//   fetch_state_t : fetch FSM encoding (BOOT, RUN, DRAIN)
//   PC_STEP       : sequential PC increment
//   PC_ALIGN_MASK : low PC bits forced to zero on redirect
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam int         PC_STEP       = 4;
  localparam logic [1:0] PC_ALIGN_MASK = 2'b11;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: I-cache request/response bus.
//   ic_req   : request valid (fetch -> cache)
//   ic_addr  : request address (fetch -> cache)
//   ic_ready : data valid, request completes this cycle (cache -> fetch)
//   ic_rdata : instruction word (cache -> fetch)
// master = fetch stage, slave = I-cache.
interface fetch_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  ic_req;
  logic [DATA_WIDTH-1:0] ic_addr;
  logic                  ic_ready;
  logic [DATA_WIDTH-1:0] ic_rdata;

  modport master (output ic_req, ic_addr, input ic_ready, ic_rdata);
  modport slave  (input ic_req, ic_addr, output ic_ready, ic_rdata);
endinterface

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry register that parks a fetched word while the
// pipeline is stalled.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture din, mark valid
//   clear    : drop the entry (wins over load)
//   din      : word to capture
//   valid    : entry present
//   data     : captured word
module fetch_hold_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues I-cache requests and presents
// {instruction, PC, PC+4} to the F/D register. Handles cache misses,
// downstream stalls (one-entry hold buffer) and execute redirects.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   stall_f                  : downstream cannot accept this cycle
//   redirect_valid/_pc       : taken branch/jump from execute
//   ic (fetch_if.master)     : I-cache request/response bus
//   instr_valid_f            : read_data_f/PC_f/PCPlus4_f carry a live instruction
//   read_data_f, PC_f, PCPlus4_f : instruction, its PC, PC+4
//   perf_fetch_cnt           : instructions accepted downstream
//   perf_miss_cyc            : cycles with ic_req & !ic_ready
// Build option: define FETCH_PERF_CNT_EN to implement the perf counters;
// otherwise both counter ports read 0 and no counter flops exist.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_f,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  fetch_if.master               ic,
  output logic                  instr_valid_f,
  output logic [DATA_WIDTH-1:0] read_data_f,
  output logic [DATA_WIDTH-1:0] PC_f,
  output logic [DATA_WIDTH-1:0] PCPlus4_f,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_miss_cyc
);

  fetch_state_t          state_q;
  logic [DATA_WIDTH-1:0] pc_q, pend_pc_q, pc_inc, rpc_al, hold_data;
  logic                  hold_valid, in_run, xfer, miss, accept;
  logic                  hold_load, hold_clr;

  assign in_run = (state_q == RUN);
  assign pc_inc = pc_q + DATA_WIDTH'(PC_STEP);
  assign rpc_al = redirect_pc & ~{{(DATA_WIDTH-2){1'b0}}, PC_ALIGN_MASK};

  // A parked word means the cache has nothing to do until it is consumed.
  assign ic.ic_req  = (state_q != BOOT) & ~hold_valid;
  assign ic.ic_addr = pc_q;

  assign xfer = ic.ic_req & ic.ic_ready;
  assign miss = ic.ic_req & ~ic.ic_ready;

  // DRAIN data belongs to a squashed path, so only RUN presents anything.
  assign instr_valid_f = in_run & ~redirect_valid & (hold_valid | xfer);
  assign read_data_f   = hold_valid ? hold_data : ic.ic_rdata;
  assign PC_f          = pc_q;
  assign PCPlus4_f     = pc_inc;

  assign accept    = instr_valid_f & ~stall_f;
  assign hold_load = in_run & ~redirect_valid & xfer & stall_f;
  assign hold_clr  = accept | (in_run & redirect_valid);

  fetch_hold_buf #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .clear (hold_clr),
    .din   (ic.ic_rdata),
    .valid (hold_valid),
    .data  (hold_data)
  );

  // A miss in flight cannot be withdrawn: a redirect then parks its target
  // in pend_pc and the FSM drains the stale response before switching.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      case (state_q)
        BOOT: state_q <= RUN;
        RUN: begin
          if (redirect_valid) begin
            if (miss) begin
              pend_pc_q <= rpc_al;
              state_q   <= DRAIN;
            end else begin
              pc_q <= rpc_al;
            end
          end else if (accept) begin
            pc_q <= pc_inc;
          end
        end
        DRAIN: begin
          if (ic.ic_ready) begin
            pc_q    <= redirect_valid ? rpc_al : pend_pc_q;
            state_q <= RUN;
          end else if (redirect_valid) begin
            pend_pc_q <= rpc_al;
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, miss_cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      miss_cyc_q  <= '0;
    end else begin
      if (accept) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (miss)   miss_cyc_q  <= miss_cyc_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_miss_cyc  = miss_cyc_q;
`else
  assign perf_fetch_cnt = 32'd0;
  assign perf_miss_cyc  = 32'd0;
`endif

endmodule
